// File: rtl/imem_pkg.sv
// Shared types and constants for the LEGv8 instruction memory.
// Fetch FSM encoding, the canonical NOP word and wait-state limits.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // ADD XZR, XZR, XZR
  localparam logic [31:0] LEGV8_NOP = 32'h8b1f03ff;

  localparam int MAX_WAIT = 7;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one read-first read.
// Ports: clk, reset, we/waddr/wdata (load), rd_en/raddr -> rdata.
module imem_ram #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [N-1:0]      wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [N-1:0]      rdata
);

  logic [N-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: a write on the capture edge is not seen here.
  // rdata only moves on a capture, so it holds the last response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rdata <= '0;
    else if (rd_en) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch.sv
// Writable instruction memory with a req/resp fetch handshake.
// Ports: clk, reset(n), fetch_req/addr/ready, fetch_valid/q/fetch_err,
//        resp_ready, load_we/addr/data, busy.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int N           = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      q,
  output logic              fetch_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [N-1:0]      load_data,
  output logic              busy
);

  localparam bit NO_WAIT = (WAIT_STATES == 0);

  fetch_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] raddr;
  logic              mis;
  logic              accept;
  logic              capture;
  logic              addr_mis;

  assign fetch_ready = reset && (state == IDLE) && !load_we;
  assign accept      = fetch_req && fetch_ready;
  assign addr_mis    = |fetch_addr[1:0];
  assign busy        = (state != IDLE);

  // With no wait states the capture happens on the accept edge,
  // so the read index comes straight from the port in IDLE.
  assign raddr   = (state == IDLE) ? fetch_addr[ADDR_W+1:2] : idx;
  assign capture = (NO_WAIT && accept)
                || ((state == WAIT) && (cnt == CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      mis         <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            idx <= fetch_addr[ADDR_W+1:2];
            mis <= addr_mis;
            if (NO_WAIT) begin
              state       <= RESP;
              fetch_valid <= 1'b1;
              fetch_err   <= addr_mis;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state       <= RESP;
            fetch_valid <= 1'b1;
            fetch_err   <= mis;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state       <= IDLE;
            fetch_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  imem_ram #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (load_we),
    .waddr (load_addr),
    .wdata (load_data),
    .rd_en (capture),
    .raddr (raddr),
    .rdata (q)
  );

endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
Parametrised, writable instruction memory for the LEGv8 datapath, with a request/response fetch handshake.
- Replaces the fixed, combinational 256x32 instruction ROM.
- Adds a program-load write port, configurable wait states and misaligned-PC detection.
- Sits between the fetch stage (PC) and the decode stage.
- Lets the processor tolerate slow memory and lets the bench load programs at run time.

Parameters:
N, 32, instruction word width in bits
ADDR_W, 8, word-index width; depth = 2**ADDR_W words
WAIT_STATES, 2, extra cycles between request acceptance and response (legal range 0..7)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W+2  byte address (the PC's low bits)
fetch_ready  out  1  request can be accepted this cycle
fetch_valid  out  1  response (q, fetch_err) valid
resp_ready  in  1  consumer accepts the response
q  out  N  fetched instruction
fetch_err  out  1  accepted address was misaligned (addr[1:0] != 0)
load_we  in  1  program-load write enable
load_addr  in  ADDR_W  load word index
load_data  in  N  load word
busy  out  1  a fetch is in flight (state is not IDLE)

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-low.
- Reset (reset=0):
  - state=IDLE.
  - fetch_valid=0, q=0, fetch_err=0, busy=0, fetch_ready=0.
  - The wait counter is cleared.
  - Memory contents are not affected by reset; power-up contents are all zero.
- Reset mid-operation: any in-flight fetch is dropped with no response. After release the block is in IDLE.
- fetch_ready = reset && state==IDLE && !load_we. Loads have priority over fetches; fetch_ready is combinational only on these signals.
- State IDLE:
  - Accept when fetch_req && fetch_ready.
  - Latch idx = fetch_addr[ADDR_W+1:2] and mis = |fetch_addr[1:0].
  - If WAIT_STATES==0, go to RESP. Otherwise go to WAIT with cnt=WAIT_STATES.
  - A request in a cycle where fetch_ready=0 is ignored, with no side effect.
- State WAIT: cnt decrements each cycle; when cnt==1, go to RESP on the next edge.
- Entering RESP (the edge of the transition):
  - q <= mem[idx], fetch_err <= mis, fetch_valid <= 1.
  - A misaligned address still returns the word at the truncated index and flags fetch_err.
- State RESP:
  - q, fetch_err and fetch_valid are held stable until resp_ready=1.
  - On resp_ready, go to IDLE on the next edge: fetch_valid <= 0, q and fetch_err hold their last value.
  - No new request is accepted while in RESP.
- Latency: request accepted at edge T gives fetch_valid high after edge T+1+WAIT_STATES.
- Throughput: at most one fetch per WAIT_STATES+2 cycles.
- Load port:
  - When load_we=1 in any state, mem[load_addr] <= load_data at the edge.
  - A load to idx on the same edge as RESP capture returns the old word (read-first).
  - A load to idx during WAIT is visible to that fetch.
  - A load in RESP does not change the already-held q.
- busy = (state != IDLE).
- Width: the word index wraps naturally at 2**ADDR_W. Address bits above ADDR_W+1 are not present on the port.

Decomposition:
- Package imem_pkg holds:
  - typedef enum fetch_state_t {IDLE, WAIT, RESP};
  - constant LEGV8_NOP = 32'h8b1f03ff (ADD XZR, XZR, XZR).
  - localparam MAX_WAIT = 7.
- Sub-module imem_ram: 2**ADDR_W x N array with one synchronous write port and a read-first synchronous read enabled by the capture strobe.
- The FSM, counter and handshake stay in imem_fetch.

Test Plan:
1. Reset released with WAIT_STATES=2; load mem[0]=32'hd2800d36 and mem[1]=32'hf80b0016; request fetch_addr=0 at cycle T -> fetch_valid rises after edge T+3 with q=32'hd2800d36 and fetch_err=0; with resp_ready=1, fetch_valid falls on the next edge.
2. Hold resp_ready=0 for 5 cycles after valid -> q and fetch_valid remain stable, fetch_ready=0, and a new fetch_req is ignored (no second response).
3. fetch_addr=10'h006 -> q=mem[1]=32'hf80b0016 with fetch_err=1.
4. fetch_req together with load_we (load_addr=4, load_data=32'hcb050083) in IDLE -> the request is not accepted; the load completes; a next-cycle fetch of address 16 returns 32'hcb050083.
5. Load mem[idx]=32'haa1f0166 on the exact RESP-capture edge -> the old word is returned; a refetch returns 32'haa1f0166.
6. Assert reset during WAIT -> no response, busy=0, memory preserved; with WAIT_STATES=0 a fetch is valid after edge T+1.
